eeprom_read_arbiter: RTL and testbench

- Synchronous read controller for the 32 KiB asynchronous EEPROM (28256-class, 15-bit address, 8-bit data, active-low CE/OE).
- Shares the single EEPROM between two requesters: port 0 is instruction fetch, port 1 is data load.
- Sequences CE/OE with a programmable access wait, then a one-cycle bus recovery.
- Read-only. The tristate data bus is resolved at the top level; this block only samples it.

---
 rtl/eeprom_arb_pkg.sv | 13 +
 rtl/eeprom_rr_arbiter2.sv | 23 ++
 rtl/eeprom_read_arbiter.sv | 170 +++++++++++++++++
 tb/tb_eeprom_read_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eeprom_arb_pkg.sv
// Shared types and widths for the EEPROM read arbiter.
package eeprom_arb_pkg;

  localparam int EEPROM_ADDR_W = 15;
  localparam int EEPROM_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RECOVER
  } arb_state_t;

endpackage

// File: rtl/eeprom_rr_arbiter2.sv
// Two-way round-robin pick; masked requesters are never granted.
module eeprom_rr_arbiter2 (
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_id
);

  logic [1:0] elig;

  always_comb begin
    elig        = req & ~mask;
    grant_valid = |elig;
    grant_id    = 1'b0;
    unique case (1'b1)
      (elig == 2'b11): grant_id = ~last_grant;
      (elig == 2'b10): grant_id = 1'b1;
      default:         grant_id = 1'b0;
    endcase
  end

endmodule

// File: rtl/eeprom_read_arbiter.sv
// Two-port read controller for a 28256-class EEPROM.
// Define EEPROM_ARB_STATS_EN to add the stat_reads/stat_conflicts counters.
module eeprom_read_arbiter
  import eeprom_arb_pkg::*;
#(
  parameter int WAIT_CYCLES = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     r0_req,
  input  logic [EEPROM_ADDR_W-1:0] r0_addr,
  output logic                     r0_ack,
  output logic [EEPROM_DATA_W-1:0] r0_data,
  input  logic                     r1_req,
  input  logic [EEPROM_ADDR_W-1:0] r1_addr,
  output logic                     r1_ack,
  output logic [EEPROM_DATA_W-1:0] r1_data,
`ifdef EEPROM_ARB_STATS_EN
  output logic [15:0]              stat_reads,
  output logic [15:0]              stat_conflicts,
`endif
  output logic [EEPROM_ADDR_W-1:0] mem_addr,
  input  logic [EEPROM_DATA_W-1:0] mem_data_in,
  output logic                     mem_ce_n,
  output logic                     mem_oe_n
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  if (WAIT_CYCLES < 1) begin : g_bad_wait
    $error("WAIT_CYCLES must be at least 1");
  end

  arb_state_t               state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     gid_q, gid_d;
  logic                     last_q, last_d;
  logic [EEPROM_ADDR_W-1:0] addr_q, addr_d;
  logic                     ce_n_q, ce_n_d;
  logic                     ack0_q, ack0_d;
  logic                     ack1_q, ack1_d;
  logic [EEPROM_DATA_W-1:0] data0_q, data0_d;
  logic [EEPROM_DATA_W-1:0] data1_q, data1_d;

  logic [1:0] req;
  logic [1:0] mask;
  logic       gnt_valid;
  logic       gnt_id;
  logic       grant_now;

  assign req  = {r1_req, r0_req};
  // The requester acked this cycle is not eligible again until next cycle
  assign mask = (state_q == RECOVER) ? (gid_q ? 2'b10 : 2'b01) : 2'b00;

  eeprom_rr_arbiter2 u_rr (
    .req         (req),
    .mask        (mask),
    .last_grant  (last_q),
    .grant_valid (gnt_valid),
    .grant_id    (gnt_id)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gid_d     = gid_q;
    last_d    = last_q;
    addr_d    = addr_q;
    ce_n_d    = 1'b1;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    data0_d   = data0_q;
    data1_d   = data1_q;
    grant_now = 1'b0;
    unique case (state_q)
      IDLE, RECOVER: begin
        state_d = IDLE;
        if (gnt_valid) begin
          grant_now = 1'b1;
          state_d   = ACCESS;
          gid_d     = gnt_id;
          last_d    = gnt_id;
          addr_d    = gnt_id ? r1_addr : r0_addr;
          cnt_d     = CNT_W'(WAIT_CYCLES - 1);
          ce_n_d    = 1'b0;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = RECOVER;
          if (gid_q) begin
            data1_d = mem_data_in;
            ack1_d  = 1'b1;
          end else begin
            data0_d = mem_data_in;
            ack0_d  = 1'b1;
          end
        end else begin
          cnt_d  = cnt_q - 1'b1;
          ce_n_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gid_q   <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      ce_n_q  <= 1'b1;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      data0_q <= '0;
      data1_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gid_q   <= gid_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      ce_n_q  <= ce_n_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
    end
  end

  assign mem_addr = addr_q;
  assign mem_ce_n = ce_n_q;
  assign mem_oe_n = ce_n_q;
  assign r0_ack   = ack0_q;
  assign r1_ack   = ack1_q;
  assign r0_data  = data0_q;
  assign r1_data  = data1_q;

`ifdef EEPROM_ARB_STATS_EN
  logic [15:0] reads_q, reads_d;
  logic [15:0] confl_q, confl_d;
  logic        both_elig;

  always_comb begin
    both_elig = &(req & ~mask);
    reads_d   = reads_q;
    confl_d   = confl_q;
    if (grant_now && reads_q != 16'hFFFF)
      reads_d = reads_q + 16'd1;
    if (grant_now && both_elig && confl_q != 16'hFFFF)
      confl_d = confl_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      reads_q <= '0;
      confl_q <= '0;
    end else begin
      reads_q <= reads_d;
      confl_q <= confl_d;
    end
  end

  assign stat_reads     = reads_q;
  assign stat_conflicts = confl_q;
`endif

endmodule

// File: tb/tb_eeprom_read_arbiter.sv
// Directed bench with a timestamp-based reference model of the arbiter.
module tb_eeprom_read_arbiter;

  localparam int W = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0] mem [0:32767];

  logic        r0_req, r1_req;
  logic [14:0] r0_addr, r1_addr;
  logic        r0_ack, r1_ack;
  logic [7:0]  r0_data, r1_data;
  logic [14:0] mem_addr;
  logic [7:0]  mem_data_in;
  logic        mem_ce_n, mem_oe_n;
`ifdef EEPROM_ARB_STATS_EN
  logic [15:0] stat_reads, stat_conflicts;
  logic [15:0] s_stat_reads, s_stat_conflicts;
`endif

  assign mem_data_in = mem[mem_addr];

  eeprom_read_arbiter #(.WAIT_CYCLES(W)) dut (
    .clock          (clk),
    .reset          (rst),
    .r0_req         (r0_req),
    .r0_addr        (r0_addr),
    .r0_ack         (r0_ack),
    .r0_data        (r0_data),
    .r1_req         (r1_req),
    .r1_addr        (r1_addr),
    .r1_ack         (r1_ack),
    .r1_data        (r1_data),
`ifdef EEPROM_ARB_STATS_EN
    .stat_reads     (stat_reads),
    .stat_conflicts (stat_conflicts),
`endif
    .mem_addr       (mem_addr),
    .mem_data_in    (mem_data_in),
    .mem_ce_n       (mem_ce_n),
    .mem_oe_n       (mem_oe_n)
  );

  // Second instance with the shortest access
  logic        s_req;
  logic [14:0] s_addr;
  logic        s_r1_req;
  logic [14:0] s_r1_addr;
  logic        s_ack0, s_ack1;
  logic [7:0]  s_data0, s_data1;
  logic [14:0] s_maddr;
  logic [7:0]  s_mdata;
  logic        s_ce_n, s_oe_n;

  assign s_r1_req  = 1'b0;
  assign s_r1_addr = 15'h0000;
  assign s_mdata   = mem[s_maddr];

  eeprom_read_arbiter #(.WAIT_CYCLES(1)) dut1 (
    .clock          (clk),
    .reset          (rst),
    .r0_req         (s_req),
    .r0_addr        (s_addr),
    .r0_ack         (s_ack0),
    .r0_data        (s_data0),
    .r1_req         (s_r1_req),
    .r1_addr        (s_r1_addr),
    .r1_ack         (s_ack1),
    .r1_data        (s_data1),
`ifdef EEPROM_ARB_STATS_EN
    .stat_reads     (s_stat_reads),
    .stat_conflicts (s_stat_conflicts),
`endif
    .mem_addr       (s_maddr),
    .mem_data_in    (s_mdata),
    .mem_ce_n       (s_ce_n),
    .mem_oe_n       (s_oe_n)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: each grant books an access window by cycle number
  int          mcyc = 0;
  int          ack_at = -1;
  int          owner = 0;
  int          n_reads = 0;
  int          n_conf = 0;
  logic [14:0] m_addr;
  logic        m_last;
  logic [7:0]  m_d0, m_d1;
  logic        m_ce_n, m_a0, m_a1;
  logic        m_valid = 1'b0;
  bit          in_acc, el0, el1, g;

  always @(posedge clk) begin
    if (rst) begin
      m_ce_n  = 1'b1;
      m_a0    = 1'b0;
      m_a1    = 1'b0;
      m_d0    = 8'h00;
      m_d1    = 8'h00;
      m_addr  = 15'h0;
      m_last  = 1'b1;
      ack_at  = -1;
      n_reads = 0;
      n_conf  = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      in_acc = (ack_at >= 0) && (mcyc >= ack_at - W) && (mcyc < ack_at);
      if (ack_at >= 0 && mcyc == ack_at - 1) begin
        if (owner == 0) m_d0 = mem[m_addr];
        else            m_d1 = mem[m_addr];
      end
      if (!in_acc) begin
        el0 = r0_req && !(ack_at == mcyc && owner == 0);
        el1 = r1_req && !(ack_at == mcyc && owner == 1);
        if (el0 || el1) begin
          g      = (el0 && el1) ? !m_last : el1;
          owner  = g ? 1 : 0;
          m_last = g;
          m_addr = g ? r1_addr : r0_addr;
          ack_at = mcyc + W + 1;
          n_reads++;
          if (el0 && el1) n_conf++;
        end
      end
      m_ce_n = !((ack_at >= 0) && (mcyc + 1 >= ack_at - W) && (mcyc + 1 < ack_at));
      m_a0   = (ack_at == mcyc + 1) && (owner == 0);
      m_a1   = (ack_at == mcyc + 1) && (owner == 1);
    end
    mcyc++;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("ce_n",   mem_ce_n, m_ce_n);
      check("oe_n",   mem_oe_n, m_ce_n);
      check("ack0",   r0_ack,   m_a0);
      check("ack1",   r1_ack,   m_a1);
      check("data0",  r0_data,  m_d0);
      check("data1",  r1_data,  m_d1);
      if (!m_ce_n) check("addr", mem_addr, m_addr);
`ifdef EEPROM_ARB_STATS_EN
      check("stat_reads", stat_reads, n_reads);
      check("stat_conf",  stat_conflicts, n_conf);
`endif
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  int ord [0:9];
  int at  [0:9];
  int nacks;

  initial begin
    for (int a = 0; a < 32768; a++) mem[a] = 8'((a * 7) + 3);
    mem[15'h0123] = 8'hA5;
    mem[15'h0000] = 8'h11;
    mem[15'h7FFF] = 8'h22;
    rst = 1'b1;
    r0_req = 1'b0; r1_req = 1'b0;
    r0_addr = '0;  r1_addr = '0;
    s_req = 1'b0;  s_addr = '0;
    tick(3);
    check("rst_ce_n", mem_ce_n, 1'b1);
    check("rst_oe_n", mem_oe_n, 1'b1);
    check("rst_addr", mem_addr, 15'h0);
    check("rst_ack",  {r0_ack, r1_ack}, 2'b00);
    check("rst_data", {r0_data, r1_data}, 16'h0);

    // Reset during the second access cycle
    rst = 1'b0;
    tick(1);
    r0_addr = 15'h0055; r0_req = 1'b1;
    tick(1);
    check("mid_acc_ce", mem_ce_n, 1'b0);
    tick(1);
    rst = 1'b1; r0_req = 1'b0;
    tick(1);
    check("mid_rst_ce", mem_ce_n, 1'b1);
    check("mid_rst_oe", mem_oe_n, 1'b1);
    check("mid_rst_ack", r0_ack, 1'b0);
    check("mid_rst_data", r0_data, 8'h00);
    rst = 1'b0;
    tick(3);
    check("mid_rst_noack", {r0_ack, r0_data}, 9'h0);

    // Single read on both instances
    r0_addr = 15'h0123; r0_req = 1'b1;
    s_addr  = 15'h0123; s_req  = 1'b1;
    tick(1);
    check("sr_c1_ce", mem_ce_n, 1'b0);
    check("sr_c1_addr", mem_addr, 15'h0123);
    check("w1_c1_ce", s_ce_n, 1'b0);
    tick(1);
    check("w1_c2_ack", s_ack0, 1'b1);
    check("w1_c2_data", s_data0, 8'hA5);
    check("w1_c2_ce", s_ce_n, 1'b1);
    s_req = 1'b0;
    tick(1);
    check("sr_c3_ce", mem_ce_n, 1'b0);
    check("w1_c3_ack", s_ack0, 1'b0);
    tick(1);
    check("sr_c4_ack", r0_ack, 1'b1);
    check("sr_c4_data", r0_data, 8'hA5);
    check("sr_c4_ce", {mem_ce_n, mem_oe_n}, 2'b11);
    r0_req = 1'b0;
    tick(2);

    // Conflict from reset: r0 first, r1 granted in r0's ack cycle
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    r0_addr = 15'h0000; r1_addr = 15'h7FFF;
    r0_req = 1'b1; r1_req = 1'b1;
    tick(4);
    check("cf_ack0", {r0_ack, r1_ack}, 2'b10);
    check("cf_data0", r0_data, 8'h11);
    r0_req = 1'b0;
    tick(1);
    check("cf_noidle", mem_ce_n, 1'b0);
    check("cf_addr1", mem_addr, 15'h7FFF);
    tick(3);
    check("cf_ack1", {r0_ack, r1_ack}, 2'b01);
    check("cf_data1", r1_data, 8'h22);
`ifdef EEPROM_ARB_STATS_EN
    check("cf_stat_reads", stat_reads, 16'd2);
    check("cf_stat_conf", stat_conflicts, 16'd1);
`endif
    r1_req = 1'b0;
    tick(2);

    // Address changes during access are ignored
    r1_addr = 15'h0010; r1_req = 1'b1;
    tick(2);
    r1_addr = 15'h0020;
    tick(1);
    check("as_addr", mem_addr, 15'h0010);
    tick(1);
    check("as_ack", r1_ack, 1'b1);
    check("as_data", r1_data, 8'h73);
    r1_req = 1'b0;
    tick(2);

    // Saturation: both re-request with a new address on every ack
    r0_addr = 15'h0100; r1_addr = 15'h0200;
    r0_req = 1'b1; r1_req = 1'b1;
    nacks = 0;
    for (int k = 1; k <= 80 && nacks < 10; k++) begin
      tick(1);
      if (r0_ack && nacks < 10) begin
        ord[nacks] = 0; at[nacks] = k; nacks++;
        r0_addr = r0_addr + 15'd1;
      end
      if (r1_ack && nacks < 10) begin
        ord[nacks] = 1; at[nacks] = k; nacks++;
        r1_addr = r1_addr + 15'd1;
      end
    end
    r0_req = 1'b0; r1_req = 1'b0;
    check("sat_count", nacks, 10);
    if (nacks == 10) begin
      check("sat_first", at[0], 4);
      for (int i = 0; i < 10; i++) check("sat_order", ord[i], i % 2);
      for (int i = 1; i < 10; i++) check("sat_gap", at[i] - at[i-1], 4);
    end
    tick(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
